// File: rtl/ahb_edac_sram.sv
// ahb_edac_sram
//   AHB-Lite subordinate in front of a single-port 39-bit SRAM ({checksum[6:0], data[31:0]}).
//   Full-word writes store the initiator's checksum as-is; reads return data and checksum
//   uncorrected. Sub-word writes do a read-modify-write: the old word is checked, merged
//   and re-encoded. Address/control parity is checked on every accepted transfer.
//
// Ports
//   s_clk_i, s_resetn_i            clock, async active-low reset
//   s_hsel_i .. s_hwdcheck_i       AHB-Lite request side (address phase + write data)
//   s_hreadyout_o, s_hresp_o       transfer done / error response
//   s_hrdata_o, s_hrdcheck_o       read data and its stored checksum
//   s_ram_*                        SRAM port, read data arrives one cycle after ce
//   s_perr_o                       one-cycle pulse: address/control parity error
//   s_uce_o                        one-cycle pulse: checksum error on the RMW read
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transfer in progress; reads are issued straight from here
// WR     | full-word write to SRAM, one wait state
// RD     | RMW read of the target word
// MRG    | check + merge + write back (or first error cycle if the word is bad)
// DONE   | write complete, port free, may accept the next transfer
// ERR1   | first cycle of ERROR response
// ERR2   | second cycle of ERROR response, may accept the next transfer
module ahb_edac_sram #(
    parameter int          DEPTH     = 4096,
    parameter int          AW        = $clog2(DEPTH),
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic          s_clk_i,
    input  logic          s_resetn_i,
    input  logic          s_hsel_i,
    input  logic          s_hready_i,
    input  logic [31:0]   s_haddr_i,
    input  logic [1:0]    s_htrans_i,
    input  logic [2:0]    s_hsize_i,
    input  logic          s_hwrite_i,
    input  logic [5:0]    s_hparity_i,
    input  logic [31:0]   s_hwdata_i,
    input  logic [6:0]    s_hwdcheck_i,
    output logic          s_hreadyout_o,
    output logic          s_hresp_o,
    output logic [31:0]   s_hrdata_o,
    output logic [6:0]    s_hrdcheck_o,
    output logic          s_ram_ce_o,
    output logic          s_ram_we_o,
    output logic [AW-1:0] s_ram_addr_o,
    output logic [38:0]   s_ram_wdata_o,
    input  logic [38:0]   s_ram_rdata_i,
    output logic          s_perr_o,
    output logic          s_uce_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_MRG, S_DONE, S_ERR1, S_ERR2
    } state_t;

    // Extended Hamming (39,32): data bit j sits at the j-th non-power-of-two position
    // starting at 3; check bit i is the XOR of data bits whose position has bit i set,
    // and bit 6 is overall parity of data and the six Hamming bits.
    function automatic logic [6:0] f_encode(input logic [31:0] d);
        logic [5:0] c;
        logic [5:0] pos;
        c   = '0;
        pos = 6'd3;
        for (int j = 0; j < 32; j++) begin
            if (d[j]) c = c ^ pos;
            pos = pos + 6'd1;
            if ((pos & (pos - 6'd1)) == 6'd0) pos = pos + 6'd1;
        end
        return {(^d) ^ (^c), c};
    endfunction

    state_t        r_state, w_next;
    logic [AW-1:0] r_waddr;
    logic [1:0]    r_addr_lo;
    logic [1:0]    r_hsize;
    logic          r_perr;
    logic          r_uce;

    logic          w_open;
    logic          w_accept;
    logic [5:0]    w_par_exp;
    logic          w_par_err;
    logic          w_range_err;
    logic          w_size_err;
    logic          w_align_err;
    logic          w_req_err;
    logic [AW-1:0] w_waddr;
    logic [6:0]    w_syn;
    logic [3:0]    w_lane_mask;
    logic [31:0]   w_merged;
    logic          w_rmw_bad;

    assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
    assign w_accept = s_hsel_i & s_htrans_i[1] & s_hready_i & w_open;
    assign w_waddr  = s_haddr_i[AW+1:2];

    assign w_par_exp = {^s_htrans_i,
                        (^s_hsize_i) ^ s_hwrite_i,
                        ^s_haddr_i[31:24], ^s_haddr_i[23:16],
                        ^s_haddr_i[15:8],  ^s_haddr_i[7:0]};
    assign w_par_err   = (w_par_exp != s_hparity_i);
    assign w_range_err = (s_haddr_i[31:AW+2] != BASE_ADDR[31:AW+2]);
    assign w_size_err  = s_hsize_i[2] | (s_hsize_i[1:0] == 2'd3);
    assign w_align_err = ((s_hsize_i == 3'd1) && s_haddr_i[0]) ||
                         ((s_hsize_i == 3'd2) && (s_haddr_i[1:0] != 2'd0));
    assign w_req_err   = w_par_err | w_range_err | w_size_err | w_align_err;

    // Syndrome of the word fetched in RD; only meaningful in MRG.
    assign w_syn     = f_encode(s_ram_rdata_i[31:0]) ^ s_ram_rdata_i[38:32];
    assign w_rmw_bad = (w_syn != 7'd0);

    always_comb begin
        w_lane_mask = 4'b1111;
        case (r_hsize)
            2'd0:    w_lane_mask = 4'b0001 << r_addr_lo;
            2'd1:    w_lane_mask = r_addr_lo[1] ? 4'b1100 : 4'b0011;
            default: w_lane_mask = 4'b1111;
        endcase
    end

    always_comb begin
        w_merged = s_ram_rdata_i[31:0];
        for (int b = 0; b < 4; b++) begin
            if (w_lane_mask[b]) w_merged[8*b +: 8] = s_hwdata_i[8*b +: 8];
        end
    end

    always_comb begin
        w_next        = r_state;
        s_hreadyout_o = 1'b1;
        s_hresp_o     = 1'b0;
        s_ram_ce_o    = 1'b0;
        s_ram_we_o    = 1'b0;
        s_ram_addr_o  = r_waddr;
        s_ram_wdata_o = {s_hwdcheck_i, s_hwdata_i};

        case (r_state)
            S_IDLE, S_DONE: begin
                w_next = S_IDLE;
            end
            S_ERR2: begin
                s_hresp_o = 1'b1;
                w_next    = S_IDLE;
            end
            S_ERR1: begin
                s_hresp_o     = 1'b1;
                s_hreadyout_o = 1'b0;
                w_next        = S_ERR2;
            end
            S_WR: begin
                s_hreadyout_o = 1'b0;
                s_ram_ce_o    = 1'b1;
                s_ram_we_o    = 1'b1;
                w_next        = S_DONE;
            end
            S_RD: begin
                s_hreadyout_o = 1'b0;
                s_ram_ce_o    = 1'b1;
                w_next        = S_MRG;
            end
            S_MRG: begin
                s_hreadyout_o = 1'b0;
                if (w_rmw_bad) begin
                    // Corrupt old word: leave it untouched, this cycle acts as ERR1.
                    s_hresp_o = 1'b1;
                    w_next    = S_ERR2;
                end else begin
                    s_ram_ce_o    = 1'b1;
                    s_ram_we_o    = 1'b1;
                    s_ram_wdata_o = {f_encode(w_merged), w_merged};
                    w_next        = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Only reachable from IDLE/DONE/ERR2, where the SRAM port is otherwise idle.
        if (w_accept) begin
            if (w_req_err) begin
                w_next = S_ERR1;
            end else if (s_hwrite_i) begin
                w_next = (s_hsize_i == 3'd2) ? S_WR : S_RD;
            end else begin
                s_ram_ce_o   = 1'b1;
                s_ram_addr_o = w_waddr;
                w_next       = S_IDLE;
            end
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            r_state   <= S_IDLE;
            r_waddr   <= '0;
            r_addr_lo <= '0;
            r_hsize   <= '0;
            r_perr    <= 1'b0;
            r_uce     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_perr  <= w_accept & w_par_err;
            r_uce   <= (r_state == S_MRG) & w_rmw_bad;
            if (w_accept) begin
                r_waddr   <= w_waddr;
                r_addr_lo <= s_haddr_i[1:0];
                r_hsize   <= s_hsize_i[1:0];
            end
        end
    end

    // Status pulses are registered: perr is seen during ERR1, uce during ERR2.
    assign s_perr_o     = r_perr;
    assign s_uce_o      = r_uce;
    assign s_hrdata_o   = s_ram_rdata_i[31:0];
    assign s_hrdcheck_o = s_ram_rdata_i[38:32];

endmodule

// File: tb/tb_ahb_edac_sram.sv
module tb_ahb_edac_sram;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hsel = 1'b0;
    logic [31:0]   haddr = '0;
    logic [1:0]    htrans = '0;
    logic [2:0]    hsize = '0;
    logic          hwrite = 1'b0;
    logic [5:0]    hparity = '0;
    logic [31:0]   hwdata = '0;
    logic [6:0]    hwdcheck = '0;
    logic          hreadyout, hresp;
    logic [31:0]   hrdata;
    logic [6:0]    hrdcheck;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [38:0]   ram_wdata;
    logic [38:0]   ram_rdata = '0;
    logic          perr, uce;

    always #5 clk = ~clk;

    ahb_edac_sram #(.DEPTH(4096), .AW(AW), .BASE_ADDR(32'h0)) dut (
        .s_clk_i(clk), .s_resetn_i(rst_n), .s_hsel_i(hsel), .s_hready_i(hreadyout),
        .s_haddr_i(haddr), .s_htrans_i(htrans), .s_hsize_i(hsize), .s_hwrite_i(hwrite),
        .s_hparity_i(hparity), .s_hwdata_i(hwdata), .s_hwdcheck_i(hwdcheck),
        .s_hreadyout_o(hreadyout), .s_hresp_o(hresp), .s_hrdata_o(hrdata),
        .s_hrdcheck_o(hrdcheck), .s_ram_ce_o(ram_ce), .s_ram_we_o(ram_we),
        .s_ram_addr_o(ram_addr), .s_ram_wdata_o(ram_wdata), .s_ram_rdata_i(ram_rdata),
        .s_perr_o(perr), .s_uce_o(uce)
    );

    // SRAM model with a preload port so only this process writes mem.
    logic [38:0]   mem [0:4095];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [38:0]   pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int ce_cnt = 0, we_cnt = 0, perr_cnt = 0, uce_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_ce) ce_cnt++;
            if (ram_we) we_cnt++;
            if (perr)   perr_cnt++;
            if (uce)    uce_cnt++;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference checksum: the Hamming check bits are the XOR of the codeword
    // positions of all set data bits.
    int pos_tab [32];
    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < 32; i++) if (d[i]) s = s ^ 6'(pos_tab[i]);
        return {(^d) ^ (^s), s};
    endfunction

    function automatic logic [5:0] par(input logic [31:0] a, input logic [1:0] t,
                                       input logic [2:0] sz, input logic wr);
        return {t[1] ^ t[0], sz[0] ^ sz[1] ^ sz[2] ^ wr,
                ^a[31:24], ^a[23:16], ^a[15:8], ^a[7:0]};
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [38:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                              input logic [5:0] pflip);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
        hparity = par(a, 2'b10, sz, wr) ^ pflip;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic ahb_xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                            input logic [31:0] wd, input logic [6:0] wc, input logic [5:0] pflip,
                            output int waits, output int errs,
                            output logic [31:0] rd, output logic [6:0] rc);
        logic done;
        addr_phase(a, sz, wr, pflip);
        @(posedge clk); #1;
        bus_idle();
        hwdata = wd; hwdcheck = wc;
        waits = 0; errs = 0; done = 1'b0; rd = '0; rc = '0;
        for (int n = 0; n < 16 && !done; n++) begin
            @(negedge clk);
            if (hresp) errs++;
            if (hreadyout) begin
                done = 1'b1; rd = hrdata; rc = hrdcheck;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        check("xfer_completes", 64'(done), 64'd1);
    endtask

    int          waits, errs, ce0, we0, perr0, uce0;
    logic [31:0] rd;
    logic [6:0]  rc;

    initial begin
        begin
            int k;
            k = 0;
            for (int p = 3; p < 39; p++) if (!$onehot(p)) begin pos_tab[k] = p; k++; end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hreadyout", 64'(hreadyout), 64'd1);
        check("rst_hresp",     64'(hresp), 64'd0);
        check("rst_ce_we",     64'({ram_ce, ram_we}), 64'd0);
        check("rst_perr_uce",  64'({perr, uce}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-word write then read back
        ahb_xfer(32'h10, 3'd2, 1'b1, 32'hDEADBEEF, 7'h2A, 6'h0, waits, errs, rd, rc);
        check("wr_waits", 64'(waits), 64'd1);
        check("wr_resp",  64'(errs), 64'd0);
        check("wr_mem",   64'(mem[4]), 64'({7'h2A, 32'hDEADBEEF}));
        ahb_xfer(32'h10, 3'd2, 1'b0, 32'h0, 7'h0, 6'h0, waits, errs, rd, rc);
        check("rd_waits", 64'(waits), 64'd0);
        check("rd_data",  64'(rd), 64'hDEADBEEF);
        check("rd_check", 64'(rc), 64'h2A);

        // Byte write, RMW on a clean word
        preload(AW'(4), {enc(32'h11223344), 32'h11223344});
        ahb_xfer(32'h13, 3'd0, 1'b1, 32'hA5000000, 7'h0, 6'h0, waits, errs, rd, rc);
        check("bwr_waits", 64'(waits), 64'd2);
        check("bwr_resp",  64'(errs), 64'd0);
        check("bwr_mem",   64'(mem[4]), 64'({enc(32'hA5223344), 32'hA5223344}));

        // Half-word write, low lanes
        preload(AW'(5), {enc(32'h55667788), 32'h55667788});
        ahb_xfer(32'h14, 3'd1, 1'b1, 32'h0000BEEF, 7'h0, 6'h0, waits, errs, rd, rc);
        check("hwr_mem", 64'(mem[5]), 64'({enc(32'h5566BEEF), 32'h5566BEEF}));

        // Half-word write over a corrupted word
        preload(AW'(6), {enc(32'hCAFE1234), 32'hCAFE1234 ^ 32'h20});
        we0 = we_cnt; uce0 = uce_cnt;
        ahb_xfer(32'h1A, 3'd1, 1'b1, 32'hBEEF0000, 7'h0, 6'h0, waits, errs, rd, rc);
        check("uce_waits",  64'(waits), 64'd2);
        check("uce_resp",   64'(errs), 64'd2);
        check("uce_pulse",  64'(uce_cnt - uce0), 64'd1);
        check("uce_no_we",  64'(we_cnt - we0), 64'd0);
        check("uce_mem",    64'(mem[6]), 64'({enc(32'hCAFE1234), 32'hCAFE1234 ^ 32'h20}));

        // Parity error on a read
        ce0 = ce_cnt; perr0 = perr_cnt;
        ahb_xfer(32'h10, 3'd2, 1'b0, 32'h0, 7'h0, 6'h04, waits, errs, rd, rc);
        check("perr_waits", 64'(waits), 64'd1);
        check("perr_resp",  64'(errs), 64'd2);
        check("perr_pulse", 64'(perr_cnt - perr0), 64'd1);
        check("perr_no_ce", 64'(ce_cnt - ce0), 64'd0);

        // Misaligned, out-of-range and oversize requests
        ce0 = ce_cnt; perr0 = perr_cnt;
        ahb_xfer(32'h12, 3'd2, 1'b0, 32'h0, 7'h0, 6'h0, waits, errs, rd, rc);
        check("misalign_resp", 64'(errs), 64'd2);
        ahb_xfer(32'h11, 3'd1, 1'b1, 32'h0, 7'h0, 6'h0, waits, errs, rd, rc);
        check("misalign_h_resp", 64'(errs), 64'd2);
        ahb_xfer(32'h4000, 3'd2, 1'b0, 32'h0, 7'h0, 6'h0, waits, errs, rd, rc);
        check("range_resp", 64'(errs), 64'd2);
        ahb_xfer(32'h0, 3'd3, 1'b0, 32'h0, 7'h0, 6'h0, waits, errs, rd, rc);
        check("size_resp", 64'(errs), 64'd2);
        check("bad_req_no_ce", 64'(ce_cnt - ce0), 64'd0);
        check("bad_req_no_perr", 64'(perr_cnt - perr0), 64'd0);

        // Write 0x10 then read 0x20 accepted in the DONE cycle
        preload(AW'(8), {7'h55, 32'h12345678});
        addr_phase(32'h10, 3'd2, 1'b1, 6'h0);
        @(posedge clk); #1;
        bus_idle();
        hwdata = 32'h0BADF00D; hwdcheck = 7'h33;
        @(negedge clk);
        check("b2b_wr_wait", 64'(hreadyout), 64'd0);
        @(posedge clk); #1;
        addr_phase(32'h20, 3'd2, 1'b0, 6'h0);
        @(negedge clk);
        check("b2b_done_ready", 64'(hreadyout), 64'd1);
        check("b2b_rd_issue", 64'({ram_ce, ram_we, ram_addr}), 64'({1'b1, 1'b0, 12'd8}));
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("b2b_rd_data", 64'({hrdcheck, hrdata}), 64'({7'h55, 32'h12345678}));
        check("b2b_wr_mem", 64'(mem[4]), 64'({7'h33, 32'h0BADF00D}));
        @(posedge clk); #1;

        // Reset asserted in the MRG cycle
        preload(AW'(9), {enc(32'h01020304), 32'h01020304});
        addr_phase(32'h24, 3'd0, 1'b1, 6'h0);
        @(posedge clk); #1;
        bus_idle();
        hwdata = 32'h000000FF;
        @(posedge clk); #1;
        @(negedge clk);
        check("mrg_we_pending", 64'(ram_we), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 64'(hreadyout), 64'd1);
        check("rst_mid_hresp", 64'(hresp), 64'd0);
        check("rst_mid_we",    64'(ram_we), 64'd0);
        @(posedge clk); #1;
        check("rst_mid_mem", 64'(mem[9]), 64'({enc(32'h01020304), 32'h01020304}));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Bus works again after reset
        ahb_xfer(32'h24, 3'd2, 1'b0, 32'h0, 7'h0, 6'h0, waits, errs, rd, rc);
        check("post_rst_rd", 64'(rd), 64'h01020304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_edac_sram.md
Name: ahb_edac_sram

Overview:
AHB-Lite subordinate that fronts a single-port synchronous SRAM whose words are 39 bits wide: 32 data bits plus a 7-bit SECDED checksum. It is the responder end of the data bus driven by the core's load/store unit.
- Full-word writes store the initiator's checksum unchanged, giving end-to-end EDAC.
- Reads return the stored data and checksum untouched; the initiator corrects them.
- Sub-word writes are merged internally by a read-modify-write (RMW) and re-encoded.
- Address/control parity is checked on every accepted transfer.

Parameters:
DEPTH, 4096, number of 39-bit SRAM words (power of two).
AW, $clog2(DEPTH), SRAM word-address width.
BASE_ADDR, 32'h0, region base; aligned to DEPTH*4.

Ports:
s_clk_i  in  1  clock
s_resetn_i  in  1  asynchronous active-low reset
s_hsel_i  in  1  subordinate select
s_hready_i  in  1  bus HREADY (muxed)
s_haddr_i  in  32  address
s_htrans_i  in  2  transfer type
s_hsize_i  in  3  transfer size
s_hwrite_i  in  1  write indicator
s_hparity_i  in  6  address/control parity
s_hwdata_i  in  32  write data
s_hwdcheck_i  in  7  write-data checksum
s_hreadyout_o  out  1  transfer done
s_hresp_o  out  1  error response
s_hrdata_o  out  32  read data
s_hrdcheck_o  out  7  read-data checksum
s_ram_ce_o  out  1  SRAM enable
s_ram_we_o  out  1  SRAM write enable
s_ram_addr_o  out  AW  SRAM word address
s_ram_wdata_o  out  39  {checksum, data}
s_ram_rdata_i  in  39  SRAM read data, 1-cycle latency
s_perr_o  out  1  parity-error pulse
s_uce_o  out  1  RMW-read EDAC error pulse

Behaviour:
- Reset values: hreadyout=1, hresp=0, ram_ce=0, ram_we=0, perr=0, uce=0, FSM=IDLE. Reset takes effect immediately mid-transfer and discards any pending write.
- Accept condition: hsel & htrans[1] & hready_i. In that cycle hold the address, size, write and word-address in registers. IDLE/BUSY transfers get a zero-wait OKAY.
- Parity check at accept:
  - p[3:0] = byte XORs of haddr.
  - p[4] = ^hsize ^ hwrite.
  - p[5] = ^htrans.
  - Any mismatch → no SRAM access, perr=1 for 1 cycle, ERROR response.
- Also ERROR, with no SRAM access: haddr[31:AW+2] != BASE_ADDR[31:AW+2]; misalignment (half-word with addr[0]=1, word with addr[1:0]!=0); hsize>2.
- ERROR response is two cycles:
  - ERR1: hresp=1, hreadyout=0.
  - ERR2: hresp=1, hreadyout=1.
  - Then IDLE.
- Read: SRAM read is issued combinationally in the accept cycle. The data phase takes zero wait states; hrdata=rdata[31:0], hrdcheck=rdata[38:32]. No correction is done here.
- Full-word write, states WR → DONE:
  - WR: write {hwdcheck, hwdata} at the registered address, hreadyout=0.
  - DONE: hreadyout=1, SRAM port free, so a new read can issue.
  - Result: 1 wait state.
- Sub-word write, states RD → MRG → DONE (2 wait states):
  - RD: read the word, hreadyout=0.
  - MRG: compute syndrome = encode(rdata[31:0]) ^ rdata[38:32].
    - Syndrome nonzero: no write, uce=1 for 1 cycle, go to ERR2 (this MRG cycle serves as ERR1 with hresp=1).
    - Otherwise replace the byte lanes selected by hsize/haddr[1:0] with the matching hwdata lanes, write {encode(merged), merged}, hreadyout=0.
  - DONE: as for full-word write.
- During wait states a new address phase is not accepted (hready_i is low); the initiator holds it.
- In DONE and ERR2 a new accept proceeds normally (back-to-back).
- ram_ce is high only in read-issue, WR and MRG-write cycles; ram_we only in WR and MRG-write cycles.

Test Plan:
- Full write 0xDEADBEEF with check 0x2A at 0x10, then read 0x10 → 1 wait state on write; read has zero wait, hrdata=0xDEADBEEF, hrdcheck=0x2A.
- Byte write 0xA5 to 0x13 over word 0x11223344 with a valid checksum → 2 wait states; stored data 0xA5223344 with checksum = encode(0xA5223344).
- Half-word write where the stored word has a flipped bit → uce pulse; hresp=1 for 2 cycles (hreadyout 0 then 1); SRAM unchanged.
- Flip hparity_i[2] on a read → perr pulse, ERROR response, ram_ce never asserted.
- Write to 0x10 followed immediately by a read of 0x20 → read accepted in the DONE cycle; data valid the next cycle.
- Assert reset during the MRG cycle → hreadyout=1, hresp=0, ram_we=0 immediately; no write occurs.
